fan_pwm_ctrl: RTL and testbench



---
 rtl/fan_pwm_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_fan_pwm_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// fan_pwm_ctrl
//
// Software-programmable PWM generator for the board fan. Configuration comes
// straight from register-file outputs. The block copies it into shadow
// registers, which are reloaded only at PWM period boundaries. The applied duty
// ramps toward its target by a fixed step per period, which soft-starts the fan.
//
// Ports
//   clk          system clock (axi_aclk domain)
//   reset        synchronous, active-high reset
//   enable       run enable; deasserting it returns to IDLE on the next clock
//   period       PWM period minus 1 (one period lasts period+1 clocks)
//   duty_target  requested high time in clocks
//   ramp_step    duty change per period; 0 jumps straight to the target
//   fan_pwm      registered PWM output
//   duty_now     duty currently applied (read-back)
//   cnt_now      current period counter value (read-back)
//   cycle_done   high on the last clock of each PWM period
//   ramping      high while the FSM is in RAMP (registered)
//
// Handshake
//   There is no valid/ready interface. Configuration inputs are treated as
//   level signals and are sampled only into the shadow registers: every clock
//   in IDLE, and at each period boundary while running. cycle_done is a pure
//   status pulse and needs no acknowledge.
// -----------------------------------------------------------------------------
module fan_pwm_ctrl #(
  parameter int   CNT_W             = 16,
  parameter logic FORCE_ON_DISABLED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_target,
  input  logic [CNT_W-1:0] ramp_step,
  output logic             fan_pwm,
  output logic [CNT_W-1:0] duty_now,
  output logic [CNT_W-1:0] cnt_now,
  output logic             cycle_done,
  output logic             ramping
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] duty_q,  duty_d;
  logic [CNT_W-1:0] per_sh,  per_d;
  logic [CNT_W-1:0] tgt_sh,  tgt_d;
  logic [CNT_W-1:0] step_sh, step_d;
  logic             fan_q,   fan_d;
  logic             ramping_q;

  logic             boundary;
  logic [CNT_W:0]   ramp_sum;
  logic [CNT_W-1:0] ramp_gap;
  logic [CNT_W-1:0] ramp_next;

  // Last clock of a period. With per_sh == 0 every running clock qualifies.
  assign boundary = (state_q != IDLE) && (cnt_q == per_sh);

  // ---------------------------------------------------------------------------
  // Next duty value for one ramp step, computed against the pre-reload shadows.
  // The sum has one extra bit so that a step near full scale saturates at the
  // target instead of wrapping. The downward gap is compared before the
  // subtraction, so the result never underflows below the target.
  // ---------------------------------------------------------------------------
  always_comb begin
    ramp_sum  = {1'b0, duty_q} + {1'b0, step_sh};
    ramp_gap  = duty_q - tgt_sh;
    ramp_next = tgt_sh;
    if (step_sh == ZERO) begin
      // The step was reloaded to 0 while ramping: treat it as "jump to the
      // target" rather than stalling in RAMP forever.
      ramp_next = tgt_sh;
    end else if (duty_q < tgt_sh) begin
      if (ramp_sum >= {1'b0, tgt_sh}) begin
        ramp_next = tgt_sh;
      end else begin
        ramp_next = ramp_sum[CNT_W-1:0];
      end
    end else if (duty_q > tgt_sh) begin
      if (ramp_gap <= step_sh) begin
        ramp_next = tgt_sh;
      end else begin
        ramp_next = duty_q - step_sh;
      end
    end else begin
      ramp_next = tgt_sh;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    per_d   = per_sh;
    tgt_d   = tgt_sh;
    step_d  = step_sh;
    fan_d   = FORCE_ON_DISABLED;

    case (state_q)
      IDLE: begin
        // Track the configuration continuously so the start decision uses
        // current values.
        per_d  = period;
        tgt_d  = duty_target;
        step_d = ramp_step;
        cnt_d  = ZERO;
        duty_d = ZERO;
        if (enable) begin
          if ((tgt_sh != ZERO) && (step_sh != ZERO)) begin
            state_d = RAMP;
          end else begin
            state_d = RUN;
            duty_d  = tgt_sh;
          end
        end
      end

      RAMP, RUN: begin
        if (!enable) begin
          // Immediate shutdown. There is no wait for the period boundary.
          state_d = IDLE;
          cnt_d   = ZERO;
          duty_d  = ZERO;
        end else begin
          // The PWM compare is against this clock's counter and duty. The
          // result appears on fan_pwm one clock later. A duty of 0 gives a
          // constant low output. A duty above per_sh gives a constant high
          // output.
          fan_d = (cnt_q < duty_q);

          if (boundary) begin
            cnt_d  = ZERO;
            per_d  = period;
            tgt_d  = duty_target;
            step_d = ramp_step;

            if (state_q == RAMP) begin
              duty_d = ramp_next;
              if (ramp_next == tgt_sh) begin
                state_d = RUN;
              end
            end else begin
              if ((duty_target != duty_q) && (ramp_step != ZERO)) begin
                // Duty holds for one more period. Movement starts at the
                // next boundary.
                state_d = RAMP;
              end else begin
                duty_d = duty_target;
              end
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = ZERO;
        duty_d  = ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= ZERO;
      duty_q    <= ZERO;
      per_sh    <= ZERO;
      tgt_sh    <= ZERO;
      step_sh   <= ZERO;
      fan_q     <= FORCE_ON_DISABLED;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      per_sh    <= per_d;
      tgt_sh    <= tgt_d;
      step_sh   <= step_d;
      fan_q     <= fan_d;
      ramping_q <= (state_d == RAMP);
    end
  end

  assign fan_pwm    = fan_q;
  assign duty_now   = duty_q;
  assign cnt_now    = cnt_q;
  assign cycle_done = boundary;
  assign ramping    = ramping_q;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fan_pwm_ctrl
//
// Directed bench for fan_pwm_ctrl. The driver pushes one expected record per
// PWM period, {ramping, duty_now, high_clocks}, into exp_q. The monitor closes
// a period on each cycle_done. It counts the fan_pwm high clocks produced by
// the period's counter values. fan_pwm lags the counter by one clock, so the
// count includes the first clock of the next period. Expected values are
// hand-computed in the driver.
// -----------------------------------------------------------------------------
module tb_fan_pwm_ctrl;

  localparam int   CNT_W = 16;
  localparam logic FORCE = 1'b0;
  localparam int   REC_W = 1 + 2*CNT_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic [CNT_W-1:0] duty_target = '0;
  logic [CNT_W-1:0] ramp_step = '0;
  logic             fan_pwm;
  logic [CNT_W-1:0] duty_now;
  logic [CNT_W-1:0] cnt_now;
  logic             cycle_done;
  logic             ramping;

  always #5 clk = ~clk;

  fan_pwm_ctrl #(
    .CNT_W(CNT_W),
    .FORCE_ON_DISABLED(FORCE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .duty_target(duty_target),
    .ramp_step(ramp_step),
    .fan_pwm(fan_pwm),
    .duty_now(duty_now),
    .cnt_now(cnt_now),
    .cycle_done(cycle_done),
    .ramping(ramping)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [REC_W-1:0] exp_q[$];
  int               checks = 0;
  int               failures = 0;
  logic             mon_en = 1'b0;

  task automatic chk(input string name, input logic [REC_W-1:0] act,
                     input logic [REC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_rec(input logic r, input logic [CNT_W-1:0] d,
                          input int unsigned h);
    logic [CNT_W-1:0] hv;
    hv = h[CNT_W-1:0];
    exp_q.push_back({r, d, hv});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: closes one period record per cycle_done
  // ---------------------------------------------------------------------------
  initial begin
    int               hi;
    int               total;
    logic             pend;
    logic             pend_ramp;
    logic [CNT_W-1:0] pend_duty;
    logic [REC_W-1:0] exp_rec;
    logic [CNT_W-1:0] tot_v;
    hi = 0;
    pend = 1'b0;
    pend_ramp = 1'b0;
    pend_duty = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hi   = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          // This clock's fan_pwm comes from the previous period's last counter value.
          total = hi + int'(fan_pwm);
          tot_v = total[CNT_W-1:0];
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL period_unexpected: got duty=%0d high=%0d, no record queued",
                     pend_duty, total);
          end else begin
            exp_rec = exp_q.pop_front();
            chk("period_record", {pend_ramp, pend_duty, tot_v}, exp_rec);
          end
          hi   = 0;
          pend = 1'b0;
        end else begin
          hi = hi + int'(fan_pwm);
        end
        if (cycle_done) begin
          pend      = 1'b1;
          pend_duty = duty_now;
          pend_ramp = ramping;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] t,
                           input logic [CNT_W-1:0] s);
    period      = p;
    duty_target = t;
    ramp_step   = s;
    tick(2);
  endtask

  task automatic start(input logic mon);
    mon_en = mon;
    enable = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_fan"},     REC_W'(fan_pwm),    REC_W'(FORCE));
    chk({tag, "_cnt"},     REC_W'(cnt_now),    '0);
    chk({tag, "_duty"},    REC_W'(duty_now),   '0);
    chk({tag, "_ramping"}, REC_W'(ramping),    '0);
    chk({tag, "_done"},    REC_W'(cycle_done), '0);
  endtask

  task automatic stop(input string tag);
    enable = 1'b0;
    mon_en = 1'b0;
    tick(1);
    check_idle(tag);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d records pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    tick(3);
    check_idle("reset");
    reset = 1'b0;
    tick(1);

    // Fixed duty: 3 high / 7 low, period of 10 clocks.
    configure(16'd9, 16'd3, 16'd0);
    start(1'b1);
    for (int i = 0; i < 3; i++) push_rec(1'b0, 16'd3, 3);
    wait_empty("fixed", 200);
    stop("fixed_off");

    // Soft start 0 -> 40 in steps of 10. ramping drops in the 40 period.
    configure(16'd99, 16'd40, 16'd10);
    start(1'b1);
    push_rec(1'b1, 16'd0, 0);
    push_rec(1'b1, 16'd10, 10);
    push_rec(1'b1, 16'd20, 20);
    push_rec(1'b1, 16'd30, 30);
    push_rec(1'b0, 16'd40, 40);
    wait_empty("ramp_up", 1000);

    // Mid-period target change takes effect only at the next boundary.
    push_rec(1'b0, 16'd40, 40);
    push_rec(1'b0, 16'd80, 80);
    tick(40);
    duty_target = 16'd80;
    ramp_step   = 16'd0;
    wait_empty("mid_write", 400);

    // Jump to 90, then ramp down to 25 in steps of 30.
    push_rec(1'b0, 16'd80, 80);
    duty_target = 16'd90;
    push_rec(1'b0, 16'd90, 90);
    tick(100);
    duty_target = 16'd25;
    ramp_step   = 16'd30;
    push_rec(1'b1, 16'd90, 90);
    push_rec(1'b1, 16'd60, 60);
    push_rec(1'b1, 16'd30, 30);
    push_rec(1'b0, 16'd25, 25);
    wait_empty("ramp_down", 1000);
    stop("ramp_down_off");

    // Saturation near full scale. The duty exceeds the period, so the output
    // stays high.
    configure(16'd9, 16'hFFF0, 16'd0);
    start(1'b1);
    push_rec(1'b0, 16'hFFF0, 10);
    wait_empty("sat_pre", 200);
    duty_target = 16'hFFFF;
    ramp_step   = 16'h0100;
    push_rec(1'b0, 16'hFFF0, 10);
    push_rec(1'b1, 16'hFFF0, 10);
    push_rec(1'b0, 16'hFFFF, 10);
    wait_empty("sat", 200);
    stop("sat_off");

    // Zero target goes straight to RUN, even with a non-zero step.
    configure(16'd9, 16'd0, 16'd5);
    start(1'b1);
    push_rec(1'b0, 16'd0, 0);
    push_rec(1'b0, 16'd0, 0);
    wait_empty("zero", 200);
    stop("zero_off");

    // Drop enable at cnt=5 while ramping.
    configure(16'd9, 16'd8, 16'd2);
    start(1'b1);
    push_rec(1'b1, 16'd0, 0);
    wait_empty("drop_pre", 200);
    tick(4);
    chk("drop_cnt",     REC_W'(cnt_now),  REC_W'(5));
    chk("drop_duty",    REC_W'(duty_now), REC_W'(2));
    chk("drop_ramping", REC_W'(ramping),  REC_W'(1));
    stop("drop");

    // Reset mid-period with enable still high: reset wins.
    configure(16'd9, 16'd3, 16'd0);
    start(1'b0);
    tick(6);
    reset = 1'b1;
    tick(1);
    check_idle("mid_reset");
    reset  = 1'b0;
    enable = 1'b0;
    tick(2);

    // period = 0: every clock is a boundary.
    configure(16'd0, 16'd1, 16'd0);
    start(1'b0);
    tick(1);
    chk("p0_done_first", REC_W'(cycle_done), REC_W'(1));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("p0_done", REC_W'(cycle_done), REC_W'(1));
      chk("p0_fan",  REC_W'(fan_pwm),    REC_W'(1));
    end
    stop("p0_off");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
